cuckoo_lookup: RTL and testbench

- Query stage downstream of the cuckoo insert block in the key-value store.
- Accepts a 32-bit key over a valid/ready handshake.
- Computes both cuckoo hash indices and reads both tables through synchronous read ports, one per table.
- Returns hit/miss, the table that holds the key, and its slot index; also keeps saturating lookup and hit statistics.

---
 rtl/cuckoo_lookup_if.sv | 35 +++
 rtl/cuckoo_lookup.sv | 69 ++++++
 tb/tb_cuckoo_lookup.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cuckoo_lookup_if.sv
// cuckoo_lookup_if: request, table read, response and statistics signals of the cuckoo lookup stage
interface cuckoo_lookup_if #(
    parameter int KEY_W  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [KEY_W-1:0]  req_key;
    logic              t1_rd_en;
    logic [ADDR_W-1:0] t1_addr;
    logic [KEY_W-1:0]  t1_rdata;
    logic              t1_occ;
    logic              t2_rd_en;
    logic [ADDR_W-1:0] t2_addr;
    logic [KEY_W-1:0]  t2_rdata;
    logic              t2_occ;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic              resp_tbl;
    logic [ADDR_W-1:0] resp_idx;
    logic [CNT_W-1:0]  stat_lookups;
    logic [CNT_W-1:0]  stat_hits;
    modport slave (
        input  req_valid, req_key, t1_rdata, t1_occ, t2_rdata, t2_occ, resp_ready,
        output req_ready, t1_rd_en, t1_addr, t2_rd_en, t2_addr,
               resp_valid, resp_hit, resp_tbl, resp_idx, stat_lookups, stat_hits
    );
    modport master (
        output req_valid, req_key, t1_rdata, t1_occ, t2_rdata, t2_occ, resp_ready,
        input  req_ready, t1_rd_en, t1_addr, t2_rd_en, t2_addr,
               resp_valid, resp_hit, resp_tbl, resp_idx, stat_lookups, stat_hits
    );
endinterface

// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: one-at-a-time two-table cuckoo key lookup with saturating statistics
module cuckoo_lookup #(
    parameter int KEY_W  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst_n,
    cuckoo_lookup_if.slave bus
);
    localparam int NSL = KEY_W / ADDR_W;
    typedef enum logic [1:0] {IDLE, READ, CMP, RESP} state_t;
    state_t            r_state, w_next;
    logic [KEY_W-1:0]  r_key;
    logic [ADDR_W-1:0] w_h1, w_h2, r_idx;
    logic              r_hit, r_tbl, w_m1, w_m2, w_hs;
    logic [CNT_W-1:0]  r_lookups, r_hits;
    // table addresses follow the registered key, so they hold between lookups
    assign w_h1 = r_key[ADDR_W-1:0];
    always_comb begin
        w_h2 = '0;
        for (int i = 1; i < NSL; i++) w_h2 ^= r_key[i*ADDR_W +: ADDR_W];
    end
    assign w_m1 = bus.t1_occ && (bus.t1_rdata == r_key);
    assign w_m2 = bus.t2_occ && (bus.t2_rdata == r_key);
    assign w_hs = (r_state == RESP) && bus.resp_ready;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = bus.req_valid ? READ : IDLE;
            READ: w_next = CMP;
            CMP:  w_next = RESP;
            RESP: w_next = bus.resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_key     <= '0;
            r_hit     <= 1'b0;
            r_tbl     <= 1'b0;
            r_idx     <= '0;
            r_lookups <= '0;
            r_hits    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) r_key <= bus.req_key;
            if (r_state == CMP) begin
                r_hit <= w_m1 | w_m2;
                r_tbl <= !w_m1 && w_m2;
                r_idx <= w_m1 ? w_h1 : w_m2 ? w_h2 : '0;
            end
            if (w_hs && !(&r_lookups)) r_lookups <= r_lookups + 1'b1;
            if (w_hs && r_hit && !(&r_hits)) r_hits <= r_hits + 1'b1;
        end
    end
    assign bus.req_ready    = r_state == IDLE;
    assign bus.t1_rd_en     = r_state == READ;
    assign bus.t2_rd_en     = r_state == READ;
    assign bus.t1_addr      = w_h1;
    assign bus.t2_addr      = w_h2;
    assign bus.resp_valid   = r_state == RESP;
    assign bus.resp_hit     = r_hit;
    assign bus.resp_tbl     = r_tbl;
    assign bus.resp_idx     = r_idx;
    assign bus.stat_lookups = r_lookups;
    assign bus.stat_hits    = r_hits;
endmodule

// File: tb/tb_cuckoo_lookup.sv
// tb_cuckoo_lookup: scoreboard bench for cuckoo_lookup with a two-table memory model and 2-bit counters
module tb_cuckoo_lookup;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    cuckoo_lookup_if #(.KEY_W(32), .ADDR_W(4), .CNT_W(2)) bus ();
    cuckoo_lookup #(.KEY_W(32), .ADDR_W(4), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [31:0] mem1 [16];
    logic [31:0] mem2 [16];
    logic        occ1 [16];
    logic        occ2 [16];
    logic [5:0]  exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_l = 0;
    int exp_h = 0;
    always @(posedge clk) begin
        if (bus.t1_rd_en) begin
            bus.t1_rdata <= mem1[bus.t1_addr];
            bus.t1_occ   <= occ1[bus.t1_addr];
        end
        if (bus.t2_rd_en) begin
            bus.t2_rdata <= mem2[bus.t2_addr];
            bus.t2_occ   <= occ2[bus.t2_addr];
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [3:0] h1f(input logic [31:0] k);
        return k[3:0];
    endfunction
    function automatic logic [3:0] h2f(input logic [31:0] k);
        return k[7:4] ^ k[11:8] ^ k[15:12] ^ k[19:16] ^ k[23:20] ^ k[27:24] ^ k[31:28];
    endfunction
    function automatic logic [5:0] model(input logic [31:0] k);
        logic [3:0] a1, a2;
        a1 = h1f(k);
        a2 = h2f(k);
        if (occ1[a1] && mem1[a1] == k) return {2'b10, a1};
        if (occ2[a2] && mem2[a2] == k) return {2'b11, a2};
        return 6'b0;
    endfunction
    task automatic accept(input logic [31:0] key);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_key   = key;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'b0, bus.req_ready}, 32'd1);
        exp_q.push_back(model(key));
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_key   = 32'hFFFF_FFFF;
        check("read_en", {30'b0, bus.t1_rd_en, bus.t2_rd_en}, 32'd3);
        check("t1_addr", {28'b0, bus.t1_addr}, {28'b0, h1f(key)});
        check("t2_addr", {28'b0, bus.t2_addr}, {28'b0, h2f(key)});
    endtask
    task automatic lookup(input logic [31:0] key, input int stall);
        logic [5:0] e;
        accept(key);
        @(negedge clk);
        check("cmp_no_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check("resp_valid_lat3", {31'b0, bus.resp_valid}, 32'd1);
        e = exp_q[0];
        if (stall > 0) begin
            bus.req_valid = 1'b1;
            bus.req_key   = 32'hDEAD_BEEF;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_valid", {31'b0, bus.resp_valid}, 32'd1);
                check("stall_resp", {26'b0, bus.resp_hit, bus.resp_tbl, bus.resp_idx}, {26'b0, e});
                check("stall_ready", {31'b0, bus.req_ready}, 32'd0);
            end
            bus.req_valid = 1'b0;
        end
        bus.resp_ready = 1'b1;
        e = exp_q.pop_front();
        check("resp", {26'b0, bus.resp_hit, bus.resp_tbl, bus.resp_idx}, {26'b0, e});
        if (exp_l < 3) exp_l++;
        if (e[5] && exp_h < 3) exp_h++;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("post_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("post_ready", {31'b0, bus.req_ready}, 32'd1);
        check("stat_lookups", {30'b0, bus.stat_lookups}, exp_l);
        check("stat_hits", {30'b0, bus.stat_hits}, exp_h);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] k;
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 32'h0; mem2[i] = 32'h0; occ1[i] = 1'b0; occ2[i] = 1'b0;
        end
        bus.req_valid  = 1'b0;
        bus.req_key    = 32'h0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, bus.req_ready}, 32'd1);
            check("idle_valid_rden", {29'b0, bus.resp_valid, bus.t1_rd_en, bus.t2_rd_en}, 32'd0);
            check("idle_stats", {28'b0, bus.stat_lookups, bus.stat_hits}, 32'd0);
        end
        mem1[5] = 32'h0000_00A5; occ1[5] = 1'b1;
        lookup(32'h0000_00A5, 0);
        mem1[5] = 32'h0000_00B5; mem2[4'hA] = 32'h0000_00A5; occ2[4'hA] = 1'b1;
        lookup(32'h0000_00A5, 0);
        mem1[5] = 32'h0000_00A5; occ1[5] = 1'b0; occ2[4'hA] = 1'b0;
        lookup(32'h0000_00A5, 0);
        lookup(32'h0000_0000, 10);
        mem1[8] = 32'h1234_5678; occ1[8] = 1'b1; mem2[0] = 32'h1234_5678; occ2[0] = 1'b1;
        lookup(32'h1234_5678, 0);
        for (int i = 0; i < 5; i++) begin
            k = $urandom;
            if (i % 2 == 0) begin
                mem1[h1f(k)] = k; occ1[h1f(k)] = 1'b1;
            end else begin
                mem2[h2f(k)] = k; occ2[h2f(k)] = 1'b1;
            end
            lookup(k, 0);
        end
        accept(32'h0000_00A5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_l = 0;
        exp_h = 0;
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_valid_rden", {29'b0, bus.resp_valid, bus.t1_rd_en, bus.t2_rd_en}, 32'd0);
        check("rst_stats", {28'b0, bus.stat_lookups, bus.stat_hits}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        occ1[5] = 1'b1;
        lookup(32'h0000_00A5, 0);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
